mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage controller that sequences every load/store between the pipeline and a variable-latency data memory.
- Checks alignment and issues a req/ready transaction.
- Stalls the pipeline until the transaction completes.
- For loads, presents the lane-aligned word plus the latched filter op to the downstream LoadFilter, which performs sign/zero extension.

Parameters:
- PROC_BITS, 32, data/address width (from constants.vh).
- TIMEOUT_CYCLES, 16, maximum cycles waiting for i_mem_ready before raising a bus error; minimum 1.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  MEM-stage instruction valid
- i_mem_read  in  1  instruction is a load
- i_mem_write  in  1  instruction is a store
- i_ls_filter_op  in  3  size/sign op: 000 B, 001 H, 011 W, 100 BU, 101 HU; x10 reserved
- i_addr  in  PROC_BITS  byte address
- i_wdata  in  PROC_BITS  store data, right-justified
- o_stall  out  1  freeze pipeline
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  PROC_BITS  aligned load word, feeds LoadFilter i_data_in
- o_ls_filter_op  out  3  latched op, feeds LoadFilter i_ls_filter_op
- o_misaligned  out  1  address exception, valid with o_done
- o_bus_error  out  1  timeout exception, valid with o_done
- o_mem_req  out  1  memory request
- o_mem_we  out  1  write enable
- o_mem_addr  out  PROC_BITS  word address, {addr[31:2],2'b00}
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  PROC_BITS  lane-replicated store data
- i_mem_ready  in  1  memory accepts write / returns read data this cycle
- i_mem_rdata  in  PROC_BITS  read data, valid with i_mem_ready

Behaviour:
- States: IDLE, ACCESS, DONE, ERR.
- Reset values: state IDLE, timeout counter 0. o_stall=0, o_done=0, o_misaligned=0, o_bus_error=0, o_mem_req=0, o_mem_we=0, o_mem_be=0, o_mem_addr=0, o_mem_wdata=0, o_rdata=0, o_ls_filter_op=000.
- An access is i_valid & (i_mem_read | i_mem_write). If both are set, read wins and the write is ignored.
- Size is taken from op[1:0]:
  - 00 byte: always aligned.
  - 01 half: illegal when addr[0]=1.
  - 11 word: illegal when addr[1:0]≠00.
  - 10: always illegal.
- IDLE, access seen, combinational path: o_stall=1 in the same cycle.
  - Illegal address or op: latch flags, go ERR. No memory request.
  - Legal: latch addr, op, we, be, wdata; go ACCESS. o_mem_req=1 from the next cycle.
- ACCESS: o_stall=1.
  - o_mem_req, o_mem_we, o_mem_addr, o_mem_be and o_mem_wdata are held stable until i_mem_ready=1.
  - On ready: o_mem_req drops the next cycle.
  - For loads, o_rdata <= i_mem_rdata >> (8*addr[1:0]).
  - Then go DONE.
- Timeout: the counter increments each ACCESS cycle without ready. Reaching TIMEOUT_CYCLES drops the request and goes ERR with o_bus_error=1.
  - Ready on the same cycle the count would reach the limit counts as success.
- DONE: o_done=1, o_stall=0. The pipeline advances on this edge; go IDLE. The still-presented i_valid is not re-accepted in DONE.
- ERR: o_done=1, o_stall=0, o_misaligned or o_bus_error=1 for this cycle only; go IDLE.
- Minimum latency is 3 cycles (accept, ACCESS with ready, DONE).
- Store byte enables and data:
  - byte: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - half: be=0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - word: be=1111, wdata unchanged.
- o_rdata and o_ls_filter_op hold their last values between loads. Stores do not modify o_rdata.
- Reset mid-ACCESS: next edge state IDLE, o_mem_req=0. A late i_mem_ready in IDLE is ignored.
- i_valid=0 in IDLE: no action, all strobes 0.

Decomposition:
- constants.vh gains: LS op encodings (LOAD_BYTE … LOAD_HEX_UNSIGNED, STORE_BYTE/HEX/WORD reusing size bits), size field encodings, state encodings, default TIMEOUT_CYCLES.
- One combinational sub-module, lsu_lane_align, computes the alignment check, byte enables, store-data replication and the load right-shift from (op, addr[1:0], data).
- The FSM, counter and registers stay in mem_access_ctrl.

Test Plan:
- LW addr 0x00000010, memory ready on 2nd ACCESS cycle with rdata 0x5787_8EC9:
  - o_mem_addr=0x10, be=1111, o_stall high 3 cycles.
  - o_done pulse with o_rdata=0x57878EC9, o_ls_filter_op=011.
- LB addr 0x00000013, rdata 0xC9_87_8E_49, ready immediately:
  - o_rdata=0x000000C9, o_ls_filter_op=000. LoadFilter yields 0xFFFFFFC9.
- SH addr 0x00000006, wdata 0x0000BEEF:
  - o_mem_we=1, be=1100, o_mem_wdata=0xBEEFBEEF, o_mem_addr=0x4.
  - o_rdata unchanged.
- LW addr 0x00000002, and separately LH addr 0x00000001:
  - No o_mem_req.
  - o_stall 1 cycle, then o_done=1 with o_misaligned=1.
- Load with i_mem_ready held 0, TIMEOUT_CYCLES=4:
  - o_mem_req high 4 cycles, then ERR with o_bus_error=1, then IDLE.
- i_reset pulsed during ACCESS:
  - Next cycle o_mem_req=0, o_stall=0, all outputs at reset values.
  - A subsequent i_mem_ready=1 produces no o_done.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage load/store controller.
package mem_access_ctrl_pkg;

    // Load/store filter op encodings; stores reuse the size bits [1:0].
    localparam logic [2:0] LOAD_BYTE          = 3'b000;
    localparam logic [2:0] LOAD_HEX           = 3'b001;
    localparam logic [2:0] LOAD_WORD          = 3'b011;
    localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'b100;
    localparam logic [2:0] LOAD_HEX_UNSIGNED  = 3'b101;
    localparam logic [2:0] STORE_BYTE         = 3'b000;
    localparam logic [2:0] STORE_HEX          = 3'b001;
    localparam logic [2:0] STORE_WORD         = 3'b011;

    // Access size field, op[1:0].
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_RSVD = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Controller state encodings.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;
    localparam logic [1:0] ST_ERR    = 2'b11;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    // Size field of a load/store op.
    function automatic logic [1:0] ls_size(input logic [2:0] op);
        return op[1:0];
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: alignment check, byte enables, store replication, load shift.
module lsu_lane_align
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned PROC_BITS = 32
) (
    input  logic [1:0]             size,
    input  logic [1:0]             addr_lo,
    input  logic [PROC_BITS-1:0]   store_data,
    input  logic [PROC_BITS-1:0]   load_data,
    output logic                   illegal_c,
    output logic [PROC_BITS/8-1:0] be_c,
    output logic [PROC_BITS-1:0]   wdata_c,
    output logic [PROC_BITS-1:0]   rdata_c
);

    localparam int unsigned BE_W    = PROC_BITS / 8;
    localparam int unsigned HALVES  = PROC_BITS / 16;

    // Size-dependent alignment, enables and lane replication.
    always_comb begin
        illegal_c = 1'b0;
        be_c      = '0;
        wdata_c   = store_data;
        case (size)
            SIZE_BYTE: begin
                be_c    = BE_W'(1) << addr_lo;
                wdata_c = {BE_W{store_data[7:0]}};
            end
            SIZE_HALF: begin
                illegal_c = addr_lo[0];
                be_c      = BE_W'(3) << addr_lo;
                wdata_c   = {HALVES{store_data[15:0]}};
            end
            SIZE_WORD: begin
                illegal_c = (addr_lo != 2'b00);
                be_c      = '1;
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase
    end

    // Right-justify the addressed lane of the returned word.
    assign rdata_c = load_data >> {addr_lo, 3'b000};

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller sequencing loads/stores against a variable-latency memory.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned PROC_BITS      = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_mem_read,
    input  logic                   i_mem_write,
    input  logic [2:0]             i_ls_filter_op,
    input  logic [PROC_BITS-1:0]   i_addr,
    input  logic [PROC_BITS-1:0]   i_wdata,
    output logic                   o_stall,
    output logic                   o_done,
    output logic [PROC_BITS-1:0]   o_rdata,
    output logic [2:0]             o_ls_filter_op,
    output logic                   o_misaligned,
    output logic                   o_bus_error,
    output logic                   o_mem_req,
    output logic                   o_mem_we,
    output logic [PROC_BITS-1:0]   o_mem_addr,
    output logic [PROC_BITS/8-1:0] o_mem_be,
    output logic [PROC_BITS-1:0]   o_mem_wdata,
    input  logic                   i_mem_ready,
    input  logic [PROC_BITS-1:0]   i_mem_rdata
);

    localparam int unsigned BE_W  = PROC_BITS / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [1:0]           addr_lo_q, addr_lo_d;
    logic [2:0]           op_q, op_d;
    logic                 done_d, mis_d, berr_d, req_d, we_d;
    logic [PROC_BITS-1:0] maddr_d, mwdata_d, rdata_d;
    logic [BE_W-1:0]      be_d;
    logic [2:0]           lsop_d;
    logic                 stall_c;
    logic                 access_c;

    logic                 illegal_c;
    logic [BE_W-1:0]      be_c;
    logic [PROC_BITS-1:0] wdata_c;
    logic [PROC_BITS-1:0] rdata_c;
    logic [1:0]           align_lo_c;

    assign access_c   = i_valid & (i_mem_read | i_mem_write);
    assign cnt_inc    = cnt_q + CNT_W'(1);
    // Shared lane logic: live address while idle, latched address while accessing.
    assign align_lo_c = (state_q == ST_ACCESS) ? addr_lo_q : i_addr[1:0];
    assign o_stall    = stall_c;

    lsu_lane_align #(
        .PROC_BITS (PROC_BITS)
    ) u_lane_align (
        .size       (ls_size(i_ls_filter_op)),
        .addr_lo    (align_lo_c),
        .store_data (i_wdata),
        .load_data  (i_mem_rdata),
        .illegal_c  (illegal_c),
        .be_c       (be_c),
        .wdata_c    (wdata_c),
        .rdata_c    (rdata_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_lo_d = addr_lo_q;
        op_d      = op_q;
        done_d    = 1'b0;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        req_d     = o_mem_req;
        we_d      = o_mem_we;
        maddr_d   = o_mem_addr;
        be_d      = o_mem_be;
        mwdata_d  = o_mem_wdata;
        rdata_d   = o_rdata;
        lsop_d    = o_ls_filter_op;
        stall_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_c) begin
                    stall_c = 1'b1;
                    if (illegal_c) begin
                        mis_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        req_d     = 1'b1;
                        we_d      = ~i_mem_read;
                        maddr_d   = {i_addr[PROC_BITS-1:2], 2'b00};
                        be_d      = be_c;
                        mwdata_d  = wdata_c;
                        addr_lo_d = i_addr[1:0];
                        op_d      = i_ls_filter_op;
                        cnt_d     = '0;
                        state_d   = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                stall_c = 1'b1;
                if (i_mem_ready) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                    if (!o_mem_we) begin
                        rdata_d = rdata_c;
                        lsop_d  = op_q;
                    end
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            addr_lo_q      <= 2'b00;
            op_q           <= 3'b000;
            o_done         <= 1'b0;
            o_misaligned   <= 1'b0;
            o_bus_error    <= 1'b0;
            o_mem_req      <= 1'b0;
            o_mem_we       <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_be       <= '0;
            o_mem_wdata    <= '0;
            o_rdata        <= '0;
            o_ls_filter_op <= 3'b000;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_lo_q      <= addr_lo_d;
            op_q           <= op_d;
            o_done         <= done_d;
            o_misaligned   <= mis_d;
            o_bus_error    <= berr_d;
            o_mem_req      <= req_d;
            o_mem_we       <= we_d;
            o_mem_addr     <= maddr_d;
            o_mem_be       <= be_d;
            o_mem_wdata    <= mwdata_d;
            o_rdata        <= rdata_d;
            o_ls_filter_op <= lsop_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl with a transaction-level model.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned TMO = 4;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_mem_read = 1'b0;
    logic          i_mem_write = 1'b0;
    logic [2:0]    i_ls_filter_op = 3'b000;
    logic [W-1:0]  i_addr = '0;
    logic [W-1:0]  i_wdata = '0;
    logic          i_mem_ready = 1'b0;
    logic [W-1:0]  i_mem_rdata = '0;
    logic          o_stall, o_done, o_misaligned, o_bus_error;
    logic          o_mem_req, o_mem_we;
    logic [W-1:0]  o_rdata, o_mem_addr, o_mem_wdata;
    logic [2:0]    o_ls_filter_op;
    logic [3:0]    o_mem_be;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    logic [31:0]   exp_rdata = '0;
    logic [2:0]    exp_op = 3'b000;

    mem_access_ctrl #(
        .PROC_BITS      (W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_valid        (i_valid),
        .i_mem_read     (i_mem_read),
        .i_mem_write    (i_mem_write),
        .i_ls_filter_op (i_ls_filter_op),
        .i_addr         (i_addr),
        .i_wdata        (i_wdata),
        .o_stall        (o_stall),
        .o_done         (o_done),
        .o_rdata        (o_rdata),
        .o_ls_filter_op (o_ls_filter_op),
        .o_misaligned   (o_misaligned),
        .o_bus_error    (o_bus_error),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_be       (o_mem_be),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_ready    (i_mem_ready),
        .i_mem_rdata    (i_mem_rdata)
    );

    always #5 i_clock = ~i_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_stall"}, 32'(o_stall), 32'd0);
        check_eq({tag, "_done"},  32'(o_done), 32'd0);
        check_eq({tag, "_mis"},   32'(o_misaligned), 32'd0);
        check_eq({tag, "_berr"},  32'(o_bus_error), 32'd0);
        check_eq({tag, "_req"},   32'(o_mem_req), 32'd0);
        check_eq({tag, "_we"},    32'(o_mem_we), 32'd0);
        check_eq({tag, "_be"},    32'(o_mem_be), 32'd0);
        check_eq({tag, "_maddr"}, o_mem_addr, 32'd0);
        check_eq({tag, "_mwd"},   o_mem_wdata, 32'd0);
        check_eq({tag, "_rdata"}, o_rdata, 32'd0);
        check_eq({tag, "_op"},    32'(o_ls_filter_op), 32'd0);
    endtask

    // One complete pipeline access; delay = ACCESS cycles before ready (>= TMO: never).
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] mem_word, input int unsigned delay);
        int unsigned a;
        bit          legal;
        bit          timed_out;
        logic [31:0] e_be, e_wd;
        a = addr % 4;
        case (op[1:0])
            2'b00:   legal = 1'b1;
            2'b01:   legal = (a % 2 == 0);
            2'b11:   legal = (a == 0);
            default: legal = 1'b0;
        endcase
        case (op[1:0])
            2'b00:   begin e_be = 32'd1 << a; e_wd = 32'(wd[7:0]) * 32'h0101_0101; end
            2'b01:   begin e_be = 32'd3 << a; e_wd = 32'(wd[15:0]) * 32'h0001_0001; end
            default: begin e_be = 32'd15;     e_wd = wd; end
        endcase
        timed_out = 1'b0;

        step();
        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_ls_filter_op = op;
        i_addr = addr; i_wdata = wd; i_mem_ready = 1'b0; i_mem_rdata = $urandom;
        @(negedge i_clock);
        check_eq("accept_stall", 32'(o_stall), 32'd1);
        check_eq("accept_req",   32'(o_mem_req), 32'd0);
        check_eq("accept_done",  32'(o_done), 32'd0);

        if (legal) begin
            for (int k = 0; k < int'(TMO); k++) begin
                step();
                i_mem_ready = (k == int'(delay));
                i_mem_rdata = (k == int'(delay)) ? mem_word : $urandom;
                @(negedge i_clock);
                check_eq("acc_stall", 32'(o_stall), 32'd1);
                check_eq("acc_req",   32'(o_mem_req), 32'd1);
                check_eq("acc_we",    32'(o_mem_we), 32'(!rd));
                check_eq("acc_addr",  o_mem_addr, addr & ~32'd3);
                check_eq("acc_be",    32'(o_mem_be), e_be);
                if (!rd) check_eq("acc_wdata", o_mem_wdata, e_wd);
                if (k == int'(delay)) break;
            end
            timed_out = (delay >= TMO);
            if (rd && !timed_out) begin
                exp_rdata = mem_word >> (8 * a);
                exp_op    = op;
            end
        end

        step();
        i_mem_ready = 1'b0;
        @(negedge i_clock);
        check_eq("end_done",  32'(o_done), 32'd1);
        check_eq("end_stall", 32'(o_stall), 32'd0);
        check_eq("end_req",   32'(o_mem_req), 32'd0);
        check_eq("end_mis",   32'(o_misaligned), 32'(!legal));
        check_eq("end_berr",  32'(o_bus_error), 32'(timed_out));
        check_eq("end_rdata", o_rdata, exp_rdata);
        if (legal && rd && !timed_out) check_eq("end_op", 32'(o_ls_filter_op), 32'(exp_op));

        step();
        i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        @(negedge i_clock);
        check_eq("idle_done",  32'(o_done), 32'd0);
        check_eq("idle_stall", 32'(o_stall), 32'd0);
        check_eq("idle_req",   32'(o_mem_req), 32'd0);
        check_eq("idle_flags", 32'({o_misaligned, o_bus_error}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ops [7];
        logic [2:0]  op;
        logic [31:0] addr;
        int unsigned rw;
        ops = '{LOAD_BYTE, LOAD_HEX, LOAD_WORD, LOAD_BYTE_UNSIGNED,
                LOAD_HEX_UNSIGNED, 3'b010, 3'b110};

        repeat (3) step();
        @(negedge i_clock);
        check_reset_values("rst");
        step();
        i_reset = 1'b0;

        // Directed cases from the access scenarios.
        run_txn(1'b1, 1'b0, LOAD_WORD,  32'h0000_0010, 32'h0, 32'h5787_8EC9, 1);
        run_txn(1'b1, 1'b0, LOAD_BYTE,  32'h0000_0013, 32'h0, 32'hC987_8E49, 0);
        run_txn(1'b0, 1'b1, STORE_HEX,  32'h0000_0006, 32'h0000_BEEF, 32'h0, 0);
        run_txn(1'b1, 1'b0, LOAD_WORD,  32'h0000_0002, 32'h0, 32'h0, 0);
        run_txn(1'b1, 1'b0, LOAD_HEX,   32'h0000_0001, 32'h0, 32'h0, 0);
        run_txn(1'b1, 1'b0, LOAD_WORD,  32'h0000_0040, 32'h0, 32'h1234_5678, 99);
        run_txn(1'b1, 1'b0, LOAD_HEX_UNSIGNED, 32'h0000_0042, 32'h0, 32'hA1B2_C3D4, TMO - 1);
        run_txn(1'b0, 1'b1, 3'b010,     32'h0000_0000, 32'h1, 32'h0, 0);
        run_txn(1'b1, 1'b1, LOAD_WORD,  32'h0000_0080, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2);
        run_txn(1'b0, 1'b1, STORE_BYTE, 32'h0000_0101, 32'h0000_00A5, 32'h0, 1);
        run_txn(1'b0, 1'b1, STORE_WORD, 32'h0000_0104, 32'h1357_9BDF, 32'h0, 99);

        // Valid low in IDLE: nothing happens.
        step();
        i_valid = 1'b0; i_mem_read = 1'b1; i_mem_write = 1'b1; i_mem_ready = 1'b1;
        repeat (3) begin
            @(negedge i_clock);
            check_eq("novalid_stall", 32'(o_stall), 32'd0);
            check_eq("novalid_req",   32'(o_mem_req), 32'd0);
            check_eq("novalid_done",  32'(o_done), 32'd0);
            step();
        end
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_ready = 1'b0;

        // Randomized accesses.
        for (int n = 0; n < 300; n++) begin
            op   = ops[$urandom_range(0, 6)];
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op[1:0] == 2'b01) addr[0] = 1'b0;
                if (op[1:0] == 2'b11) addr[1:0] = 2'b00;
            end
            rw = $urandom_range(0, 3);
            run_txn(rw != 0, rw == 0 || rw == 2, op, addr, $urandom, $urandom,
                    $urandom_range(0, TMO + 1));
        end

        // Reset in the middle of an access, then a late ready.
        step();
        i_valid = 1'b1; i_mem_read = 1'b1; i_ls_filter_op = LOAD_WORD;
        i_addr = 32'h0000_0020; i_mem_ready = 1'b0;
        @(negedge i_clock);
        check_eq("mid_accept_stall", 32'(o_stall), 32'd1);
        step();
        @(negedge i_clock);
        check_eq("mid_access_req", 32'(o_mem_req), 32'd1);
        step();
        i_reset = 1'b1; i_valid = 1'b0; i_mem_read = 1'b0;
        step();
        i_reset = 1'b0; i_mem_ready = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
        exp_rdata = '0;
        exp_op    = 3'b000;
        @(negedge i_clock);
        check_reset_values("midrst");
        repeat (2) begin
            step();
            @(negedge i_clock);
            check_eq("late_ready_done", 32'(o_done), 32'd0);
            check_eq("late_ready_req",  32'(o_mem_req), 32'd0);
        end
        step();
        i_mem_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
